// File: rtl/axi_write_arbiter_pkg.sv
// Shared types and helpers for the AXI write arbiter: FSM state encoding,
// response codes and packed-vector slice arithmetic.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } arb_state_e;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    // Low bit of requester idx's field inside a packed per-requester vector.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/axi_write_arbiter_if.sv
// Bundle of the per-requester write channels and the single shared memory-side
// write channels. The master modport is the arbiter's view.
interface axi_write_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4
);
    logic [NUM_REQ-1:0]          req_awvalid;
    logic [NUM_REQ-1:0]          req_awready;
    logic [NUM_REQ*ID_W-1:0]     req_awid;
    logic [NUM_REQ*ADDR_W-1:0]   req_awaddr;
    logic [NUM_REQ*LEN_W-1:0]    req_awlen;
    logic [NUM_REQ*3-1:0]        req_awsize;
    logic [NUM_REQ*2-1:0]        req_awburst;
    logic [NUM_REQ-1:0]          req_wvalid;
    logic [NUM_REQ-1:0]          req_wready;
    logic [NUM_REQ*DATA_W-1:0]   req_wdata;
    logic [NUM_REQ*DATA_W/8-1:0] req_wstrb;
    logic [NUM_REQ-1:0]          req_wlast;
    logic [NUM_REQ-1:0]          req_bvalid;
    logic [NUM_REQ-1:0]          req_bready;
    logic [1:0]                  req_bresp;

    logic                        m_awvalid;
    logic                        m_awready;
    logic [ID_W-1:0]             m_awid;
    logic [ADDR_W-1:0]           m_awaddr;
    logic [LEN_W-1:0]            m_awlen;
    logic [2:0]                  m_awsize;
    logic [1:0]                  m_awburst;
    logic                        m_wvalid;
    logic                        m_wready;
    logic [ID_W-1:0]             m_wid;
    logic [DATA_W-1:0]           m_wdata;
    logic [DATA_W/8-1:0]         m_wstrb;
    logic                        m_wlast;
    logic                        m_bvalid;
    logic                        m_bready;
    logic [ID_W-1:0]             m_bid;
    logic [1:0]                  m_bresp;

    modport master (
        input  req_awvalid, req_awid, req_awaddr, req_awlen, req_awsize, req_awburst,
        input  req_wvalid, req_wdata, req_wstrb, req_wlast, req_bready,
        output req_awready, req_wready, req_bvalid, req_bresp,
        output m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
        output m_wvalid, m_wid, m_wdata, m_wstrb, m_wlast, m_bready,
        input  m_awready, m_wready, m_bvalid, m_bid, m_bresp
    );

    modport slave (
        output req_awvalid, req_awid, req_awaddr, req_awlen, req_awsize, req_awburst,
        output req_wvalid, req_wdata, req_wstrb, req_wlast, req_bready,
        input  req_awready, req_wready, req_bvalid, req_bresp,
        input  m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
        input  m_wvalid, m_wid, m_wdata, m_wstrb, m_wlast, m_bready,
        output m_awready, m_wready, m_bvalid, m_bid, m_bresp
    );

endinterface

// File: rtl/axi_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req at or above ptr,
// wrapping around to bit 0.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the farthest candidate back to ptr so the closest one wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                idx = IDX_W'((int'(ptr) + i) % N);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// Shares one AXI3 write port between NUM_REQ requesters, one whole burst
// (AW, all W beats, B) at a time, with round-robin fairness.
module axi_write_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    axi_write_arbiter_if.master        bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       busy,
    output logic                       proto_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_e       state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] lat_len;
    logic [ID_W-1:0]  lat_id;
    logic             aw_dropped;

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req (bus.req_awvalid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Route the grantee's channels to memory; every other requester sees idle handshakes.
    always_comb begin
        bus.req_awready = '0;
        bus.req_wready  = '0;
        bus.req_bvalid  = '0;
        bus.m_awvalid   = 1'b0;
        bus.m_wvalid    = 1'b0;
        bus.m_wlast     = 1'b0;
        bus.m_bready    = 1'b0;
        bus.m_awid      = bus.req_awid[slice_lo(int'(grant), ID_W) +: ID_W];
        bus.m_awaddr    = bus.req_awaddr[slice_lo(int'(grant), ADDR_W) +: ADDR_W];
        bus.m_awlen     = bus.req_awlen[slice_lo(int'(grant), LEN_W) +: LEN_W];
        bus.m_awsize    = bus.req_awsize[slice_lo(int'(grant), 3) +: 3];
        bus.m_awburst   = bus.req_awburst[slice_lo(int'(grant), 2) +: 2];
        bus.m_wdata     = bus.req_wdata[slice_lo(int'(grant), DATA_W) +: DATA_W];
        bus.m_wstrb     = bus.req_wstrb[slice_lo(int'(grant), DATA_W / 8) +: DATA_W / 8];
        bus.m_wid       = lat_id;
        case (state)
            ADDR: begin
                bus.m_awvalid          = bus.req_awvalid[grant];
                bus.req_awready[grant] = bus.m_awready;
            end
            DATA: begin
                bus.m_wvalid          = bus.req_wvalid[grant];
                bus.req_wready[grant] = bus.m_wready;
                bus.m_wlast           = (beat_cnt == lat_len);
            end
            RESP: begin
                bus.m_bready          = bus.req_bready[grant];
                bus.req_bvalid[grant] = bus.m_bvalid;
            end
            default: ;
        endcase
    end

    assign bus.req_bresp = bus.m_bresp;
    assign grant_idx     = grant;
    assign busy          = (state != IDLE);

    // Burst sequencing. The last beat is decided by our own count of awlen,
    // so a requester's wrong wlast is flagged but never shortens a burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            lat_len    <= '0;
            lat_id     <= '0;
            aw_dropped <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant      <= pick_idx;
                        aw_dropped <= 1'b0;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.req_awvalid[grant] && bus.m_awready) begin
                        lat_id   <= bus.m_awid;
                        lat_len  <= bus.m_awlen;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end else if (!bus.req_awvalid[grant] && !aw_dropped) begin
                        proto_err  <= 1'b1;
                        aw_dropped <= 1'b1;
                    end
                end
                DATA: begin
                    if (bus.m_wvalid && bus.m_wready) begin
                        if (bus.req_wlast[grant] != bus.m_wlast) begin
                            proto_err <= 1'b1;
                        end
                        if (bus.m_wlast) begin
                            state <= RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (bus.m_bvalid && bus.m_bready) begin
                        if (bus.m_bid != lat_id) begin
                            proto_err <= 1'b1;
                        end
                        rr_ptr <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboard bench for axi_write_arbiter: requester and memory models drive the
// channels, expected AW/W/B traffic is queued per burst and popped on handshakes.
module tb_axi_write_arbiter;
    import axi_arb_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 4;
    localparam logic [4:0] NO_BAD = 5'h1f;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [$clog2(NUM_REQ)-1:0] grant_idx;
    logic busy;
    logic proto_err;

    always #5 clk = ~clk;

    axi_write_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W),
                           .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    axi_write_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W),
                        .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .grant_idx (grant_idx),
        .busy      (busy),
        .proto_err (proto_err)
    );

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] base;
        logic [4:0]        bad_beat;
    } job_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [31:0]       req;
    } aw_exp_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [ID_W-1:0]   id;
    } w_exp_t;

    job_t    jobq [NUM_REQ][$];
    aw_exp_t exp_aw[$];
    w_exp_t  exp_w[$];
    int      exp_b[$];

    int vec_cnt   = 0;
    int err_cnt   = 0;
    int perr_cnt  = 0;
    int busy_cnt  = 0;
    int wbeat_cnt = 0;

    // Requester models: take one queued job, present AW, then stream W beats after AW is accepted.
    job_t             cur  [NUM_REQ];
    logic [4:0]       beat [NUM_REQ];
    logic [NUM_REQ-1:0] act, awv, wv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act <= '0;
            awv <= '0;
            wv  <= '0;
            for (int r = 0; r < NUM_REQ; r++) beat[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!act[r]) begin
                    if (jobq[r].size() != 0) begin
                        cur[r]  <= jobq[r][0];
                        void'(jobq[r].pop_front());
                        act[r]  <= 1'b1;
                        awv[r]  <= 1'b1;
                        beat[r] <= '0;
                    end
                end else begin
                    if (awv[r] && bus.req_awready[r]) begin
                        awv[r] <= 1'b0;
                        wv[r]  <= 1'b1;
                    end
                    if (wv[r] && bus.req_wready[r]) begin
                        beat[r] <= beat[r] + 5'd1;
                        if (beat[r] == 5'(cur[r].len)) wv[r] <= 1'b0;
                    end
                    if (bus.req_bvalid[r] && bus.req_bready[r]) act[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.req_awvalid = awv;
        bus.req_wvalid  = wv;
        bus.req_bready  = '1;
        bus.req_awid    = '0;
        bus.req_awaddr  = '0;
        bus.req_awlen   = '0;
        bus.req_awsize  = '0;
        bus.req_awburst = '0;
        bus.req_wdata   = '0;
        bus.req_wstrb   = '1;
        bus.req_wlast   = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            bus.req_awid[r*ID_W +: ID_W]       = cur[r].id;
            bus.req_awaddr[r*ADDR_W +: ADDR_W] = cur[r].addr;
            bus.req_awlen[r*LEN_W +: LEN_W]    = cur[r].len;
            bus.req_awsize[r*3 +: 3]           = 3'd2;
            bus.req_awburst[r*2 +: 2]          = 2'b01;
            bus.req_wdata[r*DATA_W +: DATA_W]  = cur[r].base + DATA_W'(beat[r]);
            bus.req_wlast[r] = (beat[r] == 5'(cur[r].len)) ^ (beat[r] == cur[r].bad_beat);
        end
    end

    // Memory model: AW always ready, optional toggling wready, B one cycle after the last beat.
    logic            mem_wtoggle_en = 1'b0;
    logic            bid_corrupt    = 1'b0;
    logic            tog, bpend;
    logic [ID_W-1:0] bid_l;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tog   <= 1'b1;
            bpend <= 1'b0;
            bid_l <= '0;
        end else begin
            tog <= mem_wtoggle_en ? ~tog : 1'b1;
            if (bus.m_awvalid && bus.m_awready) bid_l <= bus.m_awid;
            if (bus.m_wvalid && bus.m_wready && bus.m_wlast) bpend <= 1'b1;
            if (bus.m_bvalid && bus.m_bready) bpend <= 1'b0;
        end
    end

    always_comb begin
        bus.m_awready = 1'b1;
        bus.m_wready  = tog;
        bus.m_bvalid  = bpend;
        bus.m_bid     = bid_l ^ {ID_W{bid_corrupt}};
        bus.m_bresp   = BRESP_OKAY;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                                 input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] base,
                                 input logic [4:0] bad_beat);
        job_t    j;
        aw_exp_t a;
        w_exp_t  w;
        j.id = id; j.addr = addr; j.len = len; j.base = base; j.bad_beat = bad_beat;
        jobq[r].push_back(j);
        a.addr = addr; a.len = len; a.req = 32'(r);
        exp_aw.push_back(a);
        for (int b = 0; b <= int'(len); b++) begin
            w.data = base + DATA_W'(b);
            w.last = (b == int'(len));
            w.id   = id;
            exp_w.push_back(w);
        end
        exp_b.push_back(r);
    endtask

    // One cycle: observe at the falling edge the handshakes that complete on the next rising edge.
    task automatic stepCycle();
        aw_exp_t a;
        w_exp_t  w;
        int      r;
        @(negedge clk);
        if (bus.m_awvalid && bus.m_awready) begin
            if (exp_aw.size() == 0) checkOutput("unexpected aw", 64'(exp_aw.size()), 64'd1);
            else begin
                a = exp_aw.pop_front();
                checkOutput("aw addr", 64'(bus.m_awaddr), 64'(a.addr));
                checkOutput("aw len", 64'(bus.m_awlen), 64'(a.len));
                checkOutput("grant", 64'(grant_idx), 64'(a.req));
            end
        end
        if (bus.m_wvalid && bus.m_wready) begin
            wbeat_cnt++;
            if (exp_w.size() == 0) checkOutput("unexpected w", 64'(exp_w.size()), 64'd1);
            else begin
                w = exp_w.pop_front();
                checkOutput("w data", 64'(bus.m_wdata), 64'(w.data));
                checkOutput("w last", 64'(bus.m_wlast), 64'(w.last));
                checkOutput("w id", 64'(bus.m_wid), 64'(w.id));
            end
        end
        if (bus.m_bvalid && bus.m_bready) begin
            if (exp_b.size() == 0) checkOutput("unexpected b", 64'(exp_b.size()), 64'd1);
            else begin
                r = exp_b.pop_front();
                checkOutput("b route", 64'(bus.req_bvalid), 64'(1 << r));
            end
        end
        if (proto_err) perr_cnt++;
        if (busy) busy_cnt++;
    endtask

    task automatic runBursts(input int budget);
        int n = 0;
        while ((exp_b.size() != 0 || busy) && n < budget) begin
            stepCycle();
            n++;
        end
        if (n >= budget) checkOutput("burst timeout", 64'(exp_b.size()), 64'd0);
    endtask

    function automatic logic [63:0] handshakeVec();
        return 64'({bus.m_awvalid, bus.m_wvalid, bus.m_bready,
                    bus.req_awready, bus.req_wready, bus.req_bvalid});
    endfunction

    initial begin
        int p0, b0, w0, n;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset grant", 64'(grant_idx), 64'd0);
        checkOutput("reset proto_err", 64'(proto_err), 64'd0);
        checkOutput("reset handshakes", handshakeVec(), 64'd0);
        rst = 1'b0;

        $display("[TB] simultaneous requests alternate 0,1,0,1");
        p0 = perr_cnt;
        applyStimulus(0, 4'h1, 32'h100, 4'd1, 32'h1000, NO_BAD);
        applyStimulus(1, 4'h2, 32'h200, 4'd2, 32'h2000, NO_BAD);
        applyStimulus(0, 4'h3, 32'h300, 4'd0, 32'h3000, NO_BAD);
        applyStimulus(1, 4'h4, 32'h400, 4'd1, 32'h4000, NO_BAD);
        runBursts(200);
        checkOutput("rr proto_err", 64'(perr_cnt - p0), 64'd0);

        $display("[TB] single burst req0 awlen=3");
        b0 = busy_cnt; w0 = wbeat_cnt;
        applyStimulus(0, 4'h3, 32'h10, 4'd3, 32'hA000, NO_BAD);
        runBursts(100);
        checkOutput("busy cycles", 64'(busy_cnt - b0), 64'd6);
        checkOutput("single beats", 64'(wbeat_cnt - w0), 64'd4);

        $display("[TB] toggling wready awlen=7");
        mem_wtoggle_en = 1'b1;
        w0 = wbeat_cnt;
        applyStimulus(1, 4'h5, 32'h80, 4'd7, 32'hB000, NO_BAD);
        runBursts(200);
        mem_wtoggle_en = 1'b0;
        checkOutput("toggle beats", 64'(wbeat_cnt - w0), 64'd8);
        checkOutput("toggle leftovers", 64'(exp_w.size()), 64'd0);

        $display("[TB] early wlast on beat 1");
        p0 = perr_cnt; w0 = wbeat_cnt;
        applyStimulus(1, 4'h6, 32'hC0, 4'd3, 32'hC000, 5'd1);
        runBursts(100);
        checkOutput("wlast proto_err", 64'(perr_cnt - p0), 64'd1);
        checkOutput("wlast beats", 64'(wbeat_cnt - w0), 64'd4);

        $display("[TB] bid mismatch, awlen=0");
        bid_corrupt = 1'b1;
        p0 = perr_cnt;
        applyStimulus(0, 4'h7, 32'hE0, 4'd0, 32'hD000, NO_BAD);
        runBursts(100);
        bid_corrupt = 1'b0;
        checkOutput("bid proto_err", 64'(perr_cnt - p0), 64'd1);
        checkOutput("bid back to idle", 64'(busy), 64'd0);

        $display("[TB] reset mid-data");
        applyStimulus(0, 4'h8, 32'hF0, 4'd3, 32'hE000, NO_BAD);
        w0 = wbeat_cnt; n = 0;
        while ((wbeat_cnt - w0) < 2 && n < 50) begin
            stepCycle();
            n++;
        end
        if (n >= 50) checkOutput("reset wait timeout", 64'(wbeat_cnt - w0), 64'd2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid reset handshakes", handshakeVec(), 64'd0);
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        checkOutput("mid reset grant", 64'(grant_idx), 64'd0);
        exp_aw.delete();
        exp_w.delete();
        exp_b.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] post-reset arbitration starts at req0");
        applyStimulus(0, 4'h9, 32'h140, 4'd1, 32'hF000, NO_BAD);
        applyStimulus(1, 4'hA, 32'h180, 4'd1, 32'hF100, NO_BAD);
        runBursts(200);
        checkOutput("post reset leftovers", 64'(exp_aw.size() + exp_w.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run still active at 100000 ns, required earlier finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
